// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Fetch (I) and data (D) requesters share one memory port through this arbiter.
package arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

    // Everything latched at grant time, held until the next grant.
    typedef struct packed {
        owner_t            owner;
        logic              wr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface mem_port_arbiter_if;
    import arb_pkg::*;

    logic              i_req;
    logic [DATA_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_stall;

    logic              d_rd;
    logic              d_wr;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;

    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_done;

    logic              err;

    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_done,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               m_rd, m_wr, m_addr, m_wdata, err
    );

    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, m_rdata, m_done,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               m_rd, m_wr, m_addr, m_wdata, err
    );

endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Counts consecutive D grants made while a fetch is waiting and forces the
// next grant to I once MAX_D_STREAK is reached.
module arb_streak_ctr #(
    parameter int MAX_D_STREAK = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_grant_d,
    input  logic i_grant_i,
    input  logic i_ireq,
    output logic o_force_i
);
    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] r_streak;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (i_grant_d) begin
            if (!i_ireq)
                r_streak <= '0;
            else if (r_streak != STREAK_MAX)
                r_streak <= r_streak + 1'b1;
        end else if (i_grant_i) begin
            r_streak <= '0;
        end
    end

    assign o_force_i = i_ireq & (r_streak >= STREAK_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single memory port shared by fetch (I) and data (D):
// IDLE -> ISSUE -> WAIT -> DONE, with a watchdog that aborts stuck accesses.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 3,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = 7
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    state_t            r_state;
    state_t            w_next_state;
    req_t              r_req;
    logic [CNT_W-1:0]  r_wdog;
    logic              r_m_rd;
    logic              r_m_wr;
    logic              r_i_done;
    logic              r_d_done;
    logic              r_err;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_d_pend;
    logic              w_force_i;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_finish;
    logic              w_abort;
    logic [DATA_W-1:0] w_fin_data;

    assign w_d_pend = bus.d_rd | bus.d_wr;

    arb_streak_ctr #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk       (clk),
        .rst       (rst),
        .i_grant_d (w_grant_d),
        .i_grant_i (w_grant_i),
        .i_ireq    (bus.i_req),
        .o_force_i (w_force_i)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_d_pend && !w_force_i) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ISSUE;
                end else if (bus.i_req) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: w_next_state = WAIT;
            WAIT: begin
                if (bus.m_done) begin
                    w_finish     = 1'b1;
                    w_next_state = DONE;
                end else if (r_wdog == CNT_W'(TIMEOUT - 1)) begin
                    w_abort      = 1'b1;
                    w_next_state = DONE;
                end
            end
            // DONE never arbitrates, so a requester's stale request is not re-granted.
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_fin_data = w_abort ? ERR_DATA : bus.m_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_wdog    <= '0;
            r_m_rd    <= 1'b0;
            r_m_wr    <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state  <= w_next_state;
            r_m_rd   <= 1'b0;
            r_m_wr   <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_err    <= 1'b0;

            // Write wins when a load and a store are both requested.
            if (w_grant_d) begin
                r_req  <= '{owner: OWN_D, wr: bus.d_wr, addr: bus.d_addr, wdata: bus.d_wdata};
                r_m_rd <= ~bus.d_wr;
                r_m_wr <= bus.d_wr;
            end else if (w_grant_i) begin
                r_req  <= '{owner: OWN_I, wr: 1'b0, addr: bus.i_addr, wdata: '0};
                r_m_rd <= 1'b1;
            end

            if (r_state == ISSUE)
                r_wdog <= '0;
            else if (r_state == WAIT && !bus.m_done)
                r_wdog <= r_wdog + 1'b1;

            if (w_finish || w_abort) begin
                r_err <= w_abort;
                if (r_req.owner == OWN_D) begin
                    r_d_rdata <= w_fin_data;
                    r_d_done  <= 1'b1;
                end else begin
                    r_i_rdata <= w_fin_data;
                    r_i_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.m_rd    = r_m_rd;
    assign bus.m_wr    = r_m_wr;
    assign bus.m_addr  = r_req.addr;
    assign bus.m_wdata = r_req.wdata;
    assign bus.i_rdata = r_i_rdata;
    assign bus.i_done  = r_i_done;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_done  = r_d_done;
    assign bus.err     = r_err;
    assign bus.i_stall = bus.i_req & ~r_i_done;
    assign bus.d_stall = w_d_pend & ~r_d_done;

endmodule
